mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the core's instruction-fetch port and data port.
- Sits between the core top level and a multi-cycle memory with a req/ack handshake.
- Accepts one transaction at a time and returns read data with a one-cycle valid pulse.
- Raises a stall toward the core while any request is outstanding.

---
 rtl/mem_port_arbiter_pkg.sv | 38 +++
 rtl/mem_port_arbiter_watchdog.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: widths, FSM states,
// grant encodings and the tie-break helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package mem_port_arbiter_pkg;

    // Core-wide widths: address equals the PC width, data equals XLEN.
    localparam int PC_WIDTH = 32;
    localparam int XLEN     = 32;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_REQ_I  = 3'd1,
        ARB_REQ_D  = 3'd2,
        ARB_DONE_I = 3'd3,
        ARB_DONE_D = 3'd4
    } arb_state_e;

    localparam logic ARB_GNT_I = 1'b0;
    localparam logic ARB_GNT_D = 1'b1;

    // Chooses the port to serve from the IDLE state. On a tie, fixed priority
    // favours data; round-robin favours whichever port was not served last.
    function automatic logic arb_pick(input logic inst_ce,
                                      input logic data_ce,
                                      input logic rr_en,
                                      input logic last_gnt);
        logic gnt;
        if (inst_ce && data_ce) begin
            gnt = rr_en ? ~last_gnt : ARB_GNT_D;
        end else if (data_ce) begin
            gnt = ARB_GNT_D;
        end else begin
            gnt = ARB_GNT_I;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Ack-wait watchdog: counts request cycles without an ack, flags expiry.
// Latency: expired_o is combinational on the LIMIT-th waiting cycle.
// Backpressure: none; clr_i dominates en_i.
//
// Ports: clk/rst (sync, active-high), clr_i zeroes the count, en_i marks a
// waiting cycle, expired_o asserts on the waiting cycle that reaches LIMIT.
module arb_watchdog #(
    parameter int LIMIT = 255,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds the number of waiting cycles already elapsed, so the
    // LIMIT-th waiting cycle sees LIMIT-1.
    assign expired_o = en_i && (cnt_q >= CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction-fetch and data ports.
// Latency: 3 cycles ce->valid minimum (sample, req+ack, valid pulse).
// Backpressure: stall_o holds the core while a request waits for its valid.
//
// Ports: clk/rst (sync, active-high); inst_* fetch port; data_* load/store
// port; mem_* req/ack memory side (req held until ack); stall_o to the core;
// err_o sticky watchdog timeout flag.
// Optional build macro MEM_ARB_TIMEOUT_EN adds the ack-wait watchdog that
// abandons a transaction after TIMEOUT_CYCLES; without it err_o stays 0.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = PC_WIDTH,
    parameter int DATA_W         = XLEN,
    parameter int RR_ARB         = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ce_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    input  logic              data_ce_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    arb_state_e        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              err_q, err_d;

    logic              in_req;
    logic              gnt_sel;
    logic              wd_expired;

    assign in_req = (state_q == ARB_REQ_I) || (state_q == ARB_REQ_D);

`ifdef MEM_ARB_TIMEOUT_EN
    // Count restarts while idle so every REQ_x entry begins at zero.
    arb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == ARB_IDLE),
        .en_i      (in_req && !mem_ack_i),
        .expired_o (wd_expired)
    );
`else
    // No watchdog: REQ_x waits for the ack forever. The comparison folds to
    // a constant 0 for any legal TIMEOUT_CYCLES.
    assign wd_expired = (TIMEOUT_CYCLES < 0);
`endif

    assign gnt_sel = arb_pick(inst_ce_i, data_ce_i, RR_ARB != 0, last_gnt_q);

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_d       = inst_q;
        data_rdata_d = data_rdata_q;
        err_d        = err_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (inst_ce_i || data_ce_i) begin
                    last_gnt_d = gnt_sel;
                    if (gnt_sel == ARB_GNT_D) begin
                        mem_we_d    = data_we_i;
                        mem_addr_d  = data_addr_i;
                        mem_wdata_d = data_wdata_i;
                        state_d     = ARB_REQ_D;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = inst_addr_i;
                        mem_wdata_d = '0;
                        state_d     = ARB_REQ_I;
                    end
                end
            end
            ARB_REQ_I: begin
                // A real ack wins over a watchdog expiry in the same cycle.
                if (mem_ack_i) begin
                    inst_d  = mem_rdata_i;
                    state_d = ARB_DONE_I;
                end else if (wd_expired) begin
                    inst_d  = '0;
                    err_d   = 1'b1;
                    state_d = ARB_DONE_I;
                end
            end
            ARB_REQ_D: begin
                // Writes leave data_rdata_o untouched, whether acked or abandoned.
                if (mem_ack_i) begin
                    if (!mem_we_q) begin
                        data_rdata_d = mem_rdata_i;
                    end
                    state_d = ARB_DONE_D;
                end else if (wd_expired) begin
                    if (!mem_we_q) begin
                        data_rdata_d = '0;
                    end
                    err_d   = 1'b1;
                    state_d = ARB_DONE_D;
                end
            end
            ARB_DONE_I, ARB_DONE_D: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_gnt_q   <= ARB_GNT_I;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_q       <= '0;
            data_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_q       <= inst_d;
            data_rdata_q <= data_rdata_d;
            err_q        <= err_d;
        end
    end

    // Request and valid strobes decode straight from the state register, so
    // they are glitch-free and drop on the edge after ack / after DONE.
    assign mem_req_o    = in_req;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign inst_o       = inst_q;
    assign data_rdata_o = data_rdata_q;
    assign inst_valid_o = (state_q == ARB_DONE_I);
    assign data_valid_o = (state_q == ARB_DONE_D);
    assign err_o        = err_q;

    assign stall_o = (inst_ce_i | data_ce_i) & ~inst_valid_o & ~data_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a fixed-priority instance (u_dut) and a round-robin
// instance (u_rr) share the core-side stimulus; each has its own memory
// responder. Inputs change and outputs are sampled 1ns after the falling edge.
module tb_mem_port_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TO_CYC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_ce;
    logic [AW-1:0] inst_addr;
    logic          data_ce;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;

    // memory responder controls
    logic [DW-1:0] rdata_cfg;
    logic          ack_en;
    logic [7:0]    ack_dly;
    logic          ack_force;

    // fixed-priority instance
    logic [DW-1:0] inst_o0, drd0, wd0;
    logic [AW-1:0] addr0;
    logic          iv0, dv0, req0, we0, ack0, stall0, err0;
    logic [7:0]    wcnt0;
    // round-robin instance
    logic [DW-1:0] inst_o1, drd1, wd1;
    logic [AW-1:0] addr1;
    logic          iv1, dv1, req1, we1, ack1, stall1, err1;
    logic [7:0]    wcnt1;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_ARB(0), .TIMEOUT_CYCLES(TO_CYC)) u_dut (
        .clk(clk), .rst(rst),
        .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_o(inst_o0), .inst_valid_o(iv0),
        .data_ce_i(data_ce), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(drd0), .data_valid_o(dv0),
        .mem_req_o(req0), .mem_we_o(we0), .mem_addr_o(addr0), .mem_wdata_o(wd0),
        .mem_rdata_i(rdata_cfg), .mem_ack_i(ack0), .stall_o(stall0), .err_o(err0)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_ARB(1), .TIMEOUT_CYCLES(TO_CYC)) u_rr (
        .clk(clk), .rst(rst),
        .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_o(inst_o1), .inst_valid_o(iv1),
        .data_ce_i(data_ce), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_rdata_o(drd1), .data_valid_o(dv1),
        .mem_req_o(req1), .mem_we_o(we1), .mem_addr_o(addr1), .mem_wdata_o(wd1),
        .mem_rdata_i(rdata_cfg), .mem_ack_i(ack1), .stall_o(stall1), .err_o(err1)
    );

    // Responder: acks in the (ack_dly+1)-th cycle of a request; ack_force
    // injects a one-off ack regardless of request state.
    always @(posedge clk) begin
        wcnt0 <= (!req0 || ack0) ? 8'd0 : wcnt0 + 8'd1;
        wcnt1 <= (!req1 || ack1) ? 8'd0 : wcnt1 + 8'd1;
    end
    assign ack0 = ack_force | (ack_en & req0 & (wcnt0 == ack_dly));
    assign ack1 = ack_force | (ack_en & req1 & (wcnt1 == ack_dly));

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inst_ce = 0; inst_addr = '0; data_ce = 0; data_we = 0;
        data_addr = '0; data_wdata = '0; rdata_cfg = '0; ack_en = 0; ack_dly = 0; ack_force = 0;
        repeat (3) step();
        n_vec++; if (req0 !== 1'b0) begin n_mis++; $display("FAIL reset_req: got %b want 0", req0); end
        n_vec++; if ({iv0, dv0, stall0, err0, we0} !== 5'b0) begin n_mis++;
            $display("FAIL reset_flags: got %b want 00000", {iv0, dv0, stall0, err0, we0}); end
        n_vec++; if ({inst_o0, drd0, addr0, wd0} !== 128'd0) begin n_mis++;
            $display("FAIL reset_data: got %h want 0", {inst_o0, drd0, addr0, wd0}); end
        rst = 1'b0;
        step();
        n_vec++; if (req0 !== 1'b0) begin n_mis++; $display("FAIL reset_idle_req: got %b want 0", req0); end
    endtask

    task automatic test_lone_fetch();
        int  cyc = 0;
        bit  seen = 0;
        bit  stall_bad = 0;
        bit  we_bad = 0;
        logic [AW-1:0] req_addr = '0;
        rdata_cfg = 32'h0011_0093; ack_en = 1; ack_dly = 2;
        @(negedge clk);
        inst_ce = 1; inst_addr = 32'h0000_0010;
        #1;
        n_vec++; if (stall0 !== 1'b1) begin n_mis++; $display("FAIL fetch_stall_on: got %b want 1", stall0); end
        while (!seen && cyc < 12) begin
            step();
            cyc++;
            if (iv0) seen = 1;
            else begin
                if (stall0 !== 1'b1) stall_bad = 1;
                if (req0 && req_addr == '0) req_addr = addr0;
            end
            if (we0 !== 1'b0) we_bad = 1;
        end
        n_vec++; if (!seen || cyc != 4) begin n_mis++; $display("FAIL fetch_latency: got seen=%0d cyc=%0d want cyc=4", seen, cyc); end
        n_vec++; if (inst_o0 !== 32'h0011_0093) begin n_mis++; $display("FAIL fetch_data: got %h want 00110093", inst_o0); end
        n_vec++; if (stall0 !== 1'b0 || stall_bad) begin n_mis++; $display("FAIL fetch_stall: got valid-cycle %b early-drop %b want 0/0", stall0, stall_bad); end
        n_vec++; if (we_bad || req_addr !== 32'h10) begin n_mis++; $display("FAIL fetch_mem: got we_bad=%b addr=%h want 0/00000010", we_bad, req_addr); end
        inst_ce = 0;
        step();
        n_vec++; if (iv0 !== 1'b0) begin n_mis++; $display("FAIL fetch_pulse: got %b want 0", iv0); end
    endtask

    // Both ports request continuously; record the address of each grant.
    task automatic test_arbitration();
        logic [AW-1:0] g0[4];
        logic [AW-1:0] g1[4];
        logic [AW-1:0] want_rr[4];
        int  n0 = 0, n1 = 0;
        bit  p0 = 0, p1 = 0;
        want_rr[0] = 32'h100; want_rr[1] = 32'h20; want_rr[2] = 32'h100; want_rr[3] = 32'h20;
        rdata_cfg = 32'hCAFE_0001; ack_en = 1; ack_dly = 0;
        @(negedge clk);
        inst_ce = 1; inst_addr = 32'h20; data_ce = 1; data_we = 0; data_addr = 32'h100;
        repeat (12) begin
            step();
            if (req0 && !p0 && n0 < 4) begin g0[n0] = addr0; n0++; end
            if (req1 && !p1 && n1 < 4) begin g1[n1] = addr1; n1++; end
            p0 = req0; p1 = req1;
        end
        inst_ce = 0; data_ce = 0;
        n_vec++; if (n0 != 4 || n1 != 4) begin n_mis++; $display("FAIL arb_count: got %0d/%0d want 4/4", n0, n1); end
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (k < n0 && g0[k] !== 32'h100) begin n_mis++; $display("FAIL arb_fixed[%0d]: got %h want 00000100", k, g0[k]); end
            n_vec++; if (k < n1 && g1[k] !== want_rr[k]) begin n_mis++; $display("FAIL arb_rr[%0d]: got %h want %h", k, g1[k], want_rr[k]); end
        end
        n_vec++; if (drd0 !== 32'hCAFE_0001 || inst_o1 !== 32'hCAFE_0001) begin n_mis++;
            $display("FAIL arb_rdata: got %h/%h want cafe0001", drd0, inst_o1); end
        step();
    endtask

    task automatic test_write();
        rdata_cfg = 32'h1234_5678; ack_en = 1; ack_dly = 0;
        @(negedge clk);
        data_ce = 1; data_we = 1; data_addr = 32'h200; data_wdata = 32'hDEAD_BEEF;
        step();
        n_vec++; if ({req0, we0} !== 2'b11 || wd0 !== 32'hDEAD_BEEF || addr0 !== 32'h200) begin n_mis++;
            $display("FAIL write_req: got req=%b we=%b wd=%h addr=%h want 1 1 deadbeef 00000200", req0, we0, wd0, addr0); end
        step();
        n_vec++; if (dv0 !== 1'b1 || req0 !== 1'b0) begin n_mis++; $display("FAIL write_valid: got dv=%b req=%b want 1 0", dv0, req0); end
        n_vec++; if (drd0 !== 32'hCAFE_0001) begin n_mis++; $display("FAIL write_rdata_hold: got %h want cafe0001", drd0); end
        data_ce = 0; data_we = 0;
        step();
        n_vec++; if (dv0 !== 1'b0) begin n_mis++; $display("FAIL write_pulse: got %b want 0", dv0); end
    endtask

    task automatic test_reset_mid();
        rdata_cfg = 32'h0BAD_F00D; ack_en = 0;
        @(negedge clk);
        data_ce = 1; data_addr = 32'h300;
        step();
        step();
        n_vec++; if (req0 !== 1'b1) begin n_mis++; $display("FAIL rstmid_req_before: got %b want 1", req0); end
        rst = 1;
        step();
        n_vec++; if (req0 !== 1'b0 || dv0 !== 1'b0 || drd0 !== 32'd0) begin n_mis++;
            $display("FAIL rstmid_abort: got req=%b dv=%b rd=%h want 0 0 0", req0, dv0, drd0); end
        rst = 0; data_ce = 0; ack_force = 1;
        step();
        ack_force = 0;
        n_vec++; if (req0 !== 1'b0 || dv0 !== 1'b0 || drd0 !== 32'd0) begin n_mis++;
            $display("FAIL rstmid_late_ack: got req=%b dv=%b rd=%h want 0 0 0", req0, dv0, drd0); end
        step();
        n_vec++; if (dv0 !== 1'b0) begin n_mis++; $display("FAIL rstmid_no_valid: got %b want 0", dv0); end
        // fresh read proves the FSM is back in IDLE with normal latency
        ack_en = 1; ack_dly = 0; data_ce = 1; data_addr = 32'h400;
        step();
        n_vec++; if (req0 !== 1'b1 || addr0 !== 32'h400) begin n_mis++; $display("FAIL rstmid_regrant: got req=%b addr=%h want 1 00000400", req0, addr0); end
        step();
        n_vec++; if (dv0 !== 1'b1 || drd0 !== 32'h0BAD_F00D) begin n_mis++; $display("FAIL rstmid_reread: got dv=%b rd=%h want 1 0badf00d", dv0, drd0); end
        data_ce = 0;
        step();
    endtask

`ifndef MEM_ARB_TIMEOUT_EN
    task automatic test_no_timeout();
        bit dropped = 0;
        bit early_v = 0;
        rdata_cfg = 32'h55AA_55AA; ack_en = 0;
        @(negedge clk);
        data_ce = 1; data_addr = 32'h500;
        step();
        repeat (12) begin
            if (req0 !== 1'b1) dropped = 1;
            if (dv0 !== 1'b0) early_v = 1;
            step();
        end
        n_vec++; if (dropped || early_v || err0 !== 1'b0) begin n_mis++;
            $display("FAIL nowd_wait: got dropped=%b valid=%b err=%b want 0 0 0", dropped, early_v, err0); end
        ack_force = 1;
        step();
        ack_force = 0;
        n_vec++; if (dv0 !== 1'b1 || drd0 !== 32'h55AA_55AA || err0 !== 1'b0) begin n_mis++;
            $display("FAIL nowd_done: got dv=%b rd=%h err=%b want 1 55aa55aa 0", dv0, drd0, err0); end
        data_ce = 0;
        step();
    endtask
`else
    task automatic test_timeout();
        int req_cycles = 0;
        int cyc = 0;
        rdata_cfg = 32'h7777_7777; ack_en = 0;
        @(negedge clk);
        data_ce = 1; data_addr = 32'h600;
        step();
        while (req0 && cyc < 20) begin
            req_cycles++;
            cyc++;
            step();
        end
        n_vec++; if (req_cycles != TO_CYC) begin n_mis++; $display("FAIL wd_req_cycles: got %0d want %0d", req_cycles, TO_CYC); end
        n_vec++; if (dv0 !== 1'b1 || drd0 !== 32'd0 || err0 !== 1'b1) begin n_mis++;
            $display("FAIL wd_abandon: got dv=%b rd=%h err=%b want 1 0 1", dv0, drd0, err0); end
        data_ce = 0;
        repeat (3) step();
        n_vec++; if (err0 !== 1'b1 || dv0 !== 1'b0) begin n_mis++; $display("FAIL wd_sticky: got err=%b dv=%b want 1 0", err0, dv0); end
        rst = 1;
        step();
        rst = 0;
        n_vec++; if (err0 !== 1'b0) begin n_mis++; $display("FAIL wd_clear: got %b want 0", err0); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_lone_fetch();
        test_arbitration();
        test_write();
        test_reset_mid();
`ifndef MEM_ARB_TIMEOUT_EN
        test_no_timeout();
`else
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
